ahb_arbiter: RTL and testbench
==============================

// Module: ahb_arbiter
// PURPOSE
//  AHB bus arbiter sharing the system bus (SRAM/peripherals) between N masters (cpu = master 1).
//  Takes HBUSREQx/HLOCKx, drives a one-hot HGRANT and the address-phase owner HMASTER/HMASTLOCK.
//  Supports locked transfers, a hold limit against starvation and a parked default master.
// PARAMETERS
//  NUM_MASTERS     4   number of requesting masters (2..8)
//  DEFAULT_MASTER  0   master parked on the bus when no requests are pending
//  HOLD_MAX        16  HREADY-qualified cycles an unlocked owner may keep the bus while others wait
// PORTS
//  clock      in   1            system clock, all state on rising edge
//  Rst        in   1            asynchronous, active-high reset
//  HBUSREQ    in   NUM_MASTERS  bus request, bit i = master i
//  HLOCK      in   NUM_MASTERS  locked-access request, bit i = master i
//  HTRANS     in   2            current address-phase transfer type (00 IDLE,01 BUSY,10 NONSEQ,11 SEQ)
//  HREADY     in   1            bus ready; arbiter state advances only when 1
//  HGRANT     out  NUM_MASTERS  one-hot grant, registered
//  HMASTER    out  $clog2(NUM_MASTERS)  index of master owning the address phase, registered
//  HMASTLOCK  out  1            current address phase is part of a locked sequence
// BEHAVIOUR
//  Reset (async, Rst=1): HGRANT=1<<DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0,
//   state=PARK, hold_cnt=0, rr_ptr=DEFAULT_MASTER. Reset mid-burst aborts ownership immediately.
//  HREADY=0: all registers hold; no grant, owner, counter or state change.
//  States (owner = index in HGRANT):
//   PARK : no request pending; default master granted. Any HBUSREQ -> select -> OWN/LOCK.
//   OWN  : owner granted, unlocked. Rearbitrate when HREADY=1 and
//          (HBUSREQ[owner]=0) or (hold_cnt>=HOLD_MAX, other request pending, HTRANS!=SEQ/BUSY).
//   LOCK : owner has HBUSREQ&HLOCK set; no rearbitration while both stay 1, hold limit ignored.
//          Owner drops HLOCK -> OWN; drops HBUSREQ -> rearbitrate.
//  Selection at rearbitration: requesters = HBUSREQ (current owner excluded if hold-limit expiry).
//   None -> PARK with DEFAULT_MASTER. Otherwise winner per CONFIGURATION; next state LOCK if
//   HLOCK[winner] else OWN. Winner's HBUSREQ sampled in the same edge (drop+raise same cycle OK).
//  Timing: HGRANT changes at the rearbitration edge (1 cycle after qualifying HBUSREQ).
//   HMASTER/HMASTLOCK <= granted index / HLOCK[granted] at the next HREADY=1 edge (address
//   phase follows grant), so HMASTER lags HGRANT by >=1 cycle; identical while grant is stable.
//  hold_cnt: cleared on every grant change; +1 per HREADY=1 cycle in OWN while another master
//   requests; saturates at HOLD_MAX; width $clog2(HOLD_MAX+1).
//  Invariants: HGRANT always exactly one-hot; never all-zero; owner never preempted in LOCK.
//  Requests from indices >= NUM_MASTERS do not exist; X on HBUSREQ is a bench error.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: winner = first requester scanning from rr_ptr+1 upward, wrapping
//   modulo NUM_MASTERS; rr_ptr <= winner on each grant to a non-parked master.
//  Not defined: fixed priority, lowest index requesting wins; rr_ptr unused (may be removed).
// TESTING
//  T1 reset: Rst=1 mid-cycle, HBUSREQ=4'b0110 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 async.
//  T2 single req: HBUSREQ=0010, HREADY=1 -> HGRANT=0010 next edge, HMASTER=1 edge after;
//     drop req -> HGRANT=0001 (park) next edge.
//  T3 contention (RR_EN): HBUSREQ=1110 steady, owners release in turn -> grants 1,2,3,1;
//     without macro -> grant stays/returns to master 1 each time.
//  T4 hold limit: master 1 holds with HTRANS=NONSEQ, master 2 requesting -> grant moves to 2
//     after 16 HREADY cycles; with HTRANS=SEQ at expiry, move waits for first non-SEQ cycle.
//  T5 lock: master 3 HBUSREQ+HLOCK, others requesting, 40 cycles -> HGRANT=1000 throughout,
//     HMASTLOCK=1; HLOCK drops -> hold limit applies, grant moves after 16 cycles.
//  T6 wait states: HREADY=0 for 5 cycles during request change -> HGRANT/HMASTER/hold_cnt frozen,
//     update on first HREADY=1 edge.

Source files
------------

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - AHB arbitration signal bundle between masters and arbiter
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [IW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  // Requesting side: masters plus the bus ready/transfer-type observers
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  // Arbiter side
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter with lock, hold limit and parked default master (round robin under ARB_ROUND_ROBIN_EN, fixed priority otherwise)
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int HOLD_MAX       = 16
) (
  input  logic        clock,
  input  logic        Rst,
  ahb_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [IW-1:0]          DEF_IDX  = IW'(DEFAULT_MASTER);
  localparam logic [CW-1:0]          HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);

  typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_LOCK} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  int                     scan_idx;
`endif

  logic [NUM_MASTERS-1:0] owner_mask;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   others_req;
  logic                   burst_mid;
  logic                   hold_expired;
  logic [NUM_MASTERS-1:0] cand;
  logic                   win_vld;
  logic [IW-1:0]          win_idx;

  // BUSY and SEQ are mid-burst beats; a hold-limit handover must not split them
  assign owner_mask   = ONE << owner_q;
  assign owner_req    = bus.HBUSREQ[owner_q];
  assign owner_lock   = bus.HLOCK[owner_q];
  assign others_req   = |(bus.HBUSREQ & ~owner_mask);
  assign burst_mid    = (bus.HTRANS == 2'b11) || (bus.HTRANS == 2'b01);
  assign hold_expired = (state_q == ST_OWN) && owner_req && !owner_lock &&
                        (hold_cnt_q >= HOLD_LIM) && others_req && !burst_mid;
  assign cand         = bus.HBUSREQ & ~(hold_expired ? owner_mask : '0);

  // Winner selection among the candidate requesters
  always_comb begin
    win_vld = 1'b0;
    win_idx = DEF_IDX;
`ifdef ARB_ROUND_ROBIN_EN
    scan_idx = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
      if (!win_vld && cand[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(scan_idx);
      end
    end
`else
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!win_vld && cand[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
`endif
  end

  // Next-state, grant, hold counter and address-phase owner; everything frozen while HREADY=0
  always_comb begin
    logic rearb;
    rearb       = 1'b0;
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (bus.HREADY) begin
      // The address phase follows the grant held during the previous cycle
      hmaster_d   = owner_q;
      hmastlock_d = owner_lock;
      case (state_q)
        ST_PARK: rearb = |bus.HBUSREQ;
        ST_OWN: begin
          if (!owner_req) begin
            rearb = 1'b1;
          end else if (owner_lock) begin
            state_d = ST_LOCK;
          end else if (hold_expired) begin
            rearb = 1'b1;
          end else if (others_req && (hold_cnt_q < HOLD_LIM)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_LOCK: begin
          if (!owner_req) begin
            rearb = 1'b1;
          end else if (!owner_lock) begin
            state_d = ST_OWN;
          end
        end
        default: rearb = 1'b1;
      endcase

      if (rearb) begin
        hold_cnt_d = '0;
        if (win_vld) begin
          grant_d = ONE << win_idx;
          owner_d = win_idx;
          state_d = bus.HLOCK[win_idx] ? ST_LOCK : ST_OWN;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = win_idx;
`endif
        end else begin
          grant_d = ONE << DEF_IDX;
          owner_d = DEF_IDX;
          state_d = ST_PARK;
        end
      end
    end
  end

  // State registers; reset parks the default master immediately
  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_PARK;
      grant_q     <= ONE << DEF_IDX;
      owner_q     <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      hold_cnt_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= DEF_IDX;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed bench for ahb_arbiter
module tb_ahb_arbiter;
  logic clock;
  logic Rst;
  int   n_checks;
  int   n_pass;

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS(4),
    .DEFAULT_MASTER(0),
    .HOLD_MAX(16)
  ) dut (
    .clock(clock),
    .Rst(Rst),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Rst = 1'b1;
    bus.HBUSREQ = 4'b0000;
    bus.HLOCK   = 4'b0000;
    bus.HTRANS  = 2'b00;
    bus.HREADY  = 1'b1;
    step(2);
    Rst = 1'b0;
    step(1);
    check("rst_grant", 32'(bus.HGRANT), 32'h1);
    check("rst_hmaster", 32'(bus.HMASTER), 32'h0);
    check("rst_hmastlock", 32'(bus.HMASTLOCK), 32'h0);

    // T2 single request, grant then lagging HMASTER, then park
    bus.HBUSREQ = 4'b0010;
    step(1);
    check("t2_grant", 32'(bus.HGRANT), 32'h2);
    check("t2_hmaster_lag", 32'(bus.HMASTER), 32'h0);
    step(1);
    check("t2_hmaster", 32'(bus.HMASTER), 32'h1);
    bus.HBUSREQ = 4'b0000;
    step(1);
    check("t2_park_grant", 32'(bus.HGRANT), 32'h1);
    check("t2_park_hmaster_lag", 32'(bus.HMASTER), 32'h1);
    step(1);
    check("t2_park_hmaster", 32'(bus.HMASTER), 32'h0);

    // T1 asynchronous reset in the middle of an ownership
    bus.HBUSREQ = 4'b0110;
    step(2);
`ifdef ARB_ROUND_ROBIN_EN
    check("t1_pre_grant", 32'(bus.HGRANT), 32'h4);
    check("t1_pre_hmaster", 32'(bus.HMASTER), 32'h2);
`else
    check("t1_pre_grant", 32'(bus.HGRANT), 32'h2);
    check("t1_pre_hmaster", 32'(bus.HMASTER), 32'h1);
`endif
    #2;
    Rst = 1'b1;
    #1;
    check("t1_async_grant", 32'(bus.HGRANT), 32'h1);
    check("t1_async_hmaster", 32'(bus.HMASTER), 32'h0);
    check("t1_async_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
    bus.HBUSREQ = 4'b0000;
    step(1);
    Rst = 1'b0;
    step(1);
    check("t1_after_grant", 32'(bus.HGRANT), 32'h1);

    // T3 contention, owners release in turn
    bus.HBUSREQ = 4'b1110;
    step(1);
    check("t3_grant_a", 32'(bus.HGRANT), 32'h2);
    bus.HBUSREQ = 4'b1100;
    step(1);
    check("t3_grant_b", 32'(bus.HGRANT), 32'h4);
    bus.HBUSREQ = 4'b1010;
    step(1);
`ifdef ARB_ROUND_ROBIN_EN
    check("t3_grant_c", 32'(bus.HGRANT), 32'h8);
`else
    check("t3_grant_c", 32'(bus.HGRANT), 32'h2);
`endif
    bus.HBUSREQ = 4'b0110;
    step(1);
    check("t3_grant_d", 32'(bus.HGRANT), 32'h2);
    bus.HBUSREQ = 4'b0000;
    step(1);
    check("t3_park", 32'(bus.HGRANT), 32'h1);

    // T4 hold limit with NONSEQ, then deferred by SEQ
    bus.HTRANS  = 2'b10;
    bus.HBUSREQ = 4'b0010;
    step(1);
    check("t4_grant1", 32'(bus.HGRANT), 32'h2);
    bus.HBUSREQ = 4'b0110;
    step(16);
    check("t4_hold_16", 32'(bus.HGRANT), 32'h2);
    step(1);
    check("t4_moved_2", 32'(bus.HGRANT), 32'h4);
    bus.HTRANS = 2'b11;
    step(16);
    check("t4_seq_hold", 32'(bus.HGRANT), 32'h4);
    step(3);
    check("t4_seq_blocked", 32'(bus.HGRANT), 32'h4);
    bus.HTRANS = 2'b10;
    step(1);
    check("t4_nonseq_moved", 32'(bus.HGRANT), 32'h2);
    bus.HBUSREQ = 4'b0000;
    bus.HTRANS  = 2'b00;
    step(1);
    check("t4_park", 32'(bus.HGRANT), 32'h1);

    // T5 locked owner is never preempted; hold limit resumes once HLOCK drops
    bus.HBUSREQ = 4'b1000;
    bus.HLOCK   = 4'b1000;
    step(1);
    check("t5_grant3", 32'(bus.HGRANT), 32'h8);
    bus.HBUSREQ = 4'b1110;
    for (int c = 0; c < 40; c++) begin
      step(1);
      check("t5_lock_grant", 32'(bus.HGRANT), 32'h8);
    end
    check("t5_hmaster", 32'(bus.HMASTER), 32'h3);
    check("t5_hmastlock", 32'(bus.HMASTLOCK), 32'h1);
    bus.HLOCK = 4'b0000;
    step(17);
    check("t5_unlock_hold", 32'(bus.HGRANT), 32'h8);
    check("t5_hmastlock_off", 32'(bus.HMASTLOCK), 32'h0);
    step(1);
    check("t5_unlock_moved", 32'(bus.HGRANT), 32'h2);
    bus.HBUSREQ = 4'b0000;
    step(2);
    check("t5_park", 32'(bus.HGRANT), 32'h1);
    check("t5_park_hmaster", 32'(bus.HMASTER), 32'h0);

    // T6 wait states freeze grant, owner and hold counter
    bus.HREADY  = 1'b0;
    bus.HBUSREQ = 4'b0100;
    step(5);
    check("t6_frozen_grant", 32'(bus.HGRANT), 32'h1);
    check("t6_frozen_hmaster", 32'(bus.HMASTER), 32'h0);
    bus.HREADY = 1'b1;
    step(1);
    check("t6_grant2", 32'(bus.HGRANT), 32'h4);
    check("t6_hmaster_lag", 32'(bus.HMASTER), 32'h0);
    step(1);
    check("t6_hmaster2", 32'(bus.HMASTER), 32'h2);
    bus.HBUSREQ = 4'b0110;
    step(10);
    bus.HREADY = 1'b0;
    step(5);
    check("t6_wait_grant", 32'(bus.HGRANT), 32'h4);
    bus.HREADY = 1'b1;
    step(6);
    check("t6_cnt_frozen", 32'(bus.HGRANT), 32'h4);
    step(1);
    check("t6_moved", 32'(bus.HGRANT), 32'h2);

    bus.HBUSREQ = 4'b0000;
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
